// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system reset sequencer.
//   - state_e     : sequencer states
//   - cnt_width() : bits needed to hold the values 0..cycles
//   - DEF_*       : default parameter values for rst_seq_ctrl
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    RELEASE,
    RUN,
    SOFT
  } state_e;

  localparam int   DEF_NUM_CH      = 4;
  localparam int   DEF_POR_CYCLES  = 16;
  localparam int   DEF_STAGE_GAP   = 8;
  localparam int   DEF_SOFT_CYCLES = 4;
  localparam int   DEF_TICK_DIV    = 50;
  localparam int   DEF_CNT_W       = 16;
  localparam logic DEF_RST_ACTIVE  = 1'b0;

  // Smallest width (at least 1) whose unsigned range covers 0..cycles.
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_tick_gen.sv
// Periodic clock-enable generator.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   en    : counting enable; while low the divider is cleared and tick is 0
//   tick  : registered one-cycle pulse every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// System reset sequencer and tick generator.
// Holds NUM_CH reset domains after power-on, waits for PLL lock, releases the
// domains in ascending order STAGE_GAP cycles apart, then runs a periodic
// tick. Channels 1..NUM_CH-1 can be soft-reset from RUN; channel 0 is the
// always-on domain. Loss of lock re-sequences everything (without POR hold).
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   pll_locked   : PLL lock status, synchronous to clk
//   soft_rst_req : soft reset request, level-sampled, honoured only in RUN
//   rst_out      : per-channel reset, RST_ACTIVE = held in reset
//   ready        : all channels released
//   tick         : one-cycle enable pulse every TICK_DIV cycles while ready
module rst_seq_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int   NUM_CH      = DEF_NUM_CH,
  parameter int   POR_CYCLES  = DEF_POR_CYCLES,
  parameter int   STAGE_GAP   = DEF_STAGE_GAP,
  parameter int   SOFT_CYCLES = DEF_SOFT_CYCLES,
  parameter int   TICK_DIV    = DEF_TICK_DIV,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RST_ACTIVE  = DEF_RST_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic              tick
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (NUM_CH < 2 || POR_CYCLES < 1 || STAGE_GAP < 1 || SOFT_CYCLES < 1 ||
      TICK_DIV < 1 || CNT_W < 1 || CNT_W > 32 ||
      longint'(POR_CYCLES) >= CNT_LIMIT || longint'(STAGE_GAP) >= CNT_LIMIT ||
      longint'(SOFT_CYCLES) >= CNT_LIMIT || longint'(TICK_DIV) >= CNT_LIMIT)
  begin : g_bad_params
    $error("rst_seq_ctrl: illegal parameter combination");
  end

  // ch_idx must also hold NUM_CH, the value it reaches after the last release.
  localparam int IDX_W = cnt_width(NUM_CH);

  localparam logic [CNT_W-1:0]  POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]  SOFT_LAST  = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_CH    = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ALL_ACTIVE = {NUM_CH{RST_ACTIVE}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  ch_q,    ch_d;
  logic [NUM_CH-1:0] rst_q,   rst_d;
  logic              ready_q, ready_d;
  logic              tick_en;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    case (state_q)
      HOLD: begin
        // pll_locked is deliberately ignored until the hold has elapsed.
        if (cnt_q == POR_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = RELEASE;
          cnt_d   = '0;
          ch_d    = '0;
        end
      end

      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == IDX_W'(k)) rst_d[k] = ~RST_ACTIVE;
          end
          ch_d  = ch_q + 1'b1;
          cnt_d = '0;
          if (ch_q == LAST_CH) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (soft_rst_req) begin
          state_d             = SOFT;
          cnt_d               = '0;
          ready_d             = 1'b0;
          rst_d[NUM_CH-1:1]   = {(NUM_CH-1){RST_ACTIVE}};
        end
      end

      SOFT: begin
        // Re-release starts at channel 1; channel 0 never dropped.
        if (cnt_q == SOFT_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          ch_d    = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        ch_d    = '0;
        rst_d   = ALL_ACTIVE;
        ready_d = 1'b0;
      end
    endcase

    // Loss of lock outranks soft reset and any release progress.
    if (state_q inside {RELEASE, RUN, SOFT} && !pll_locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      ch_d    = '0;
      rst_d   = ALL_ACTIVE;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_q   <= ALL_ACTIVE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_out = rst_q;
  assign ready   = ready_q;

  // The divider only runs while ready is high now and stays high across this
  // edge: it starts counting the edge after ready rises, and tick is cleared
  // on the very edge that ready falls.
  assign tick_en = ready_q & ready_d;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tick  (tick)
  );

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl. Two instances (default parameters and
// a small sweep set with active-high resets) share one stimulus stream. A
// timestamp-based model predicts every output after every edge.
module tb_rst_seq_ctrl;

  localparam int   NCH0 = 4, POR0 = 16, GAP0 = 8, SOFT0 = 4, TD0 = 50;
  localparam logic ACT0 = 1'b0;
  localparam int   NCH1 = 2, POR1 = 3, GAP1 = 1, SOFT1 = 2, TD1 = 1;
  localparam logic ACT1 = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b1;
  logic soft_rst_req = 1'b0;

  logic [NCH0-1:0] rst0;
  logic            ready0, tick0;
  logic [NCH1-1:0] rst1;
  logic            ready1, tick1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_CH(NCH0), .POR_CYCLES(POR0), .STAGE_GAP(GAP0), .SOFT_CYCLES(SOFT0),
    .TICK_DIV(TD0), .CNT_W(16), .RST_ACTIVE(ACT0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .rst_out(rst0), .ready(ready0), .tick(tick0)
  );

  rst_seq_ctrl #(
    .NUM_CH(NCH1), .POR_CYCLES(POR1), .STAGE_GAP(GAP1), .SOFT_CYCLES(SOFT1),
    .TICK_DIV(TD1), .CNT_W(8), .RST_ACTIVE(ACT1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .rst_out(rst1), .ready(ready1), .tick(tick1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int   p_nch[2]  = '{NCH0, NCH1};
  int   p_por[2]  = '{POR0, POR1};
  int   p_gap[2]  = '{GAP0, GAP1};
  int   p_soft[2] = '{SOFT0, SOFT1};
  int   p_td[2]   = '{TD0, TD1};
  logic p_act[2]  = '{ACT0, ACT1};

  // Timestamps (edge indices); -1 means "not in that phase".
  int por_end[2]   = '{-1, -1};  // edge at which the POR hold completes
  int rel_start[2] = '{-1, -1};  // edge at which the current release run began
  int first_ch[2]  = '{0, 0};    // first channel of the current release run
  int soft_at[2]   = '{-1, -1};  // edge at which a soft reset was accepted
  int ready_at[2]  = '{-1, -1};  // edge at which ready rose

  logic [7:0] e_rst[2]   = '{8'h00, 8'h00};
  logic       e_ready[2] = '{1'b0, 1'b0};
  logic       e_tick[2]  = '{1'b0, 1'b0};

  task automatic all_active(input int i);
    e_rst[i] = '0;
    for (int k = 0; k < p_nch[i]; k++) e_rst[i][k] = p_act[i];
  endtask

  task automatic model_step(input int i, input int e, input logic r, input logic p, input logic s);
    int el;
    int k;
    if (!r) begin
      por_end[i]   = e + p_por[i];
      rel_start[i] = -1;
      soft_at[i]   = -1;
      ready_at[i]  = -1;
      all_active(i);
      e_ready[i] = 1'b0;
      e_tick[i]  = 1'b0;
      return;
    end
    e_tick[i] = 1'b0;
    if (por_end[i] >= 0) begin
      if (e == por_end[i]) por_end[i] = -1;
      return;
    end
    if (rel_start[i] < 0 && soft_at[i] < 0 && ready_at[i] < 0) begin
      if (p) begin
        rel_start[i] = e;
        first_ch[i]  = 0;
      end
      return;
    end
    if (!p) begin
      rel_start[i] = -1;
      soft_at[i]   = -1;
      ready_at[i]  = -1;
      all_active(i);
      e_ready[i] = 1'b0;
      return;
    end
    if (soft_at[i] >= 0) begin
      if (e == soft_at[i] + p_soft[i]) begin
        soft_at[i]   = -1;
        rel_start[i] = e;
        first_ch[i]  = 1;
      end
      return;
    end
    if (rel_start[i] >= 0) begin
      el = e - rel_start[i];
      if (el % p_gap[i] == 0) begin
        k = first_ch[i] + el / p_gap[i] - 1;
        e_rst[i][k] = ~p_act[i];
        if (k == p_nch[i] - 1) begin
          rel_start[i] = -1;
          ready_at[i]  = e;
          e_ready[i]   = 1'b1;
        end
      end
      return;
    end
    if (s) begin
      soft_at[i]  = e;
      ready_at[i] = -1;
      e_ready[i]  = 1'b0;
      for (int c = 1; c < p_nch[i]; c++) e_rst[i][c] = p_act[i];
      return;
    end
    e_tick[i] = ((e - ready_at[i]) % p_td[i] == 0);
  endtask

  int n_edge  = 0;
  int rel0    = 0;
  bit started = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i, n_edge, rst_n, pll_locked, soft_rst_req);
    if (!rst_n) rel0 = n_edge + 1;
    n_edge++;
    started = 1;
  end

  // Single compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (started) begin
      check("rst_out dut0", 32'(rst0), 32'(e_rst[0]));
      check("ready dut0", 32'(ready0), 32'(e_ready[0]));
      check("tick dut0", 32'(tick0), 32'(e_tick[0]));
      check("rst_out dut1", 32'(rst1), 32'(e_rst[1]));
      check("ready dut1", 32'(ready1), 32'(e_ready[1]));
      check("tick dut1", 32'(tick1), 32'(e_tick[1]));
    end
  end

  // Advance (at negedges) until the last edge taken has offset `o` from edge 0.
  task automatic goto(input int o);
    while (n_edge - 1 - rel0 < o) @(negedge clk);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int soft_left;
    soft_left = 0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Power-on with lock present; sweep instance pinned first.
    goto(3);   check("pin sweep held", 32'(rst1), 32'(2'b11));
    goto(4);   check("pin sweep ch0", 32'(rst1), 32'(2'b10));
    goto(5);   check("pin sweep ch1", 32'(rst1), 32'(2'b00));
               check("pin sweep ready", 32'(ready1), 32'd1);
    goto(6);   check("pin sweep tick", 32'(tick1), 32'd1);
    goto(23);  check("pin ch0 held", 32'(rst0), 32'(4'b0000));
    goto(24);  check("pin ch0 rel", 32'(rst0), 32'(4'b0001));
    goto(32);  check("pin ch1 rel", 32'(rst0), 32'(4'b0011));
    goto(40);  check("pin ch2 rel", 32'(rst0), 32'(4'b0111));
    goto(47);  check("pin ready low", 32'(ready0), 32'd0);
    goto(48);  check("pin ch3 rel", 32'(rst0), 32'(4'b1111));
               check("pin ready high", 32'(ready0), 32'd1);
    goto(97);  check("pin no tick", 32'(tick0), 32'd0);
    goto(98);  check("pin first tick", 32'(tick0), 32'd1);
    goto(99);  check("pin tick pulse", 32'(tick0), 32'd0);
    goto(148); check("pin second tick", 32'(tick0), 32'd1);

    // Soft reset from RUN.
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    check("pin soft rst", 32'(rst0), 32'(4'b0001));
    check("pin soft ready", 32'(ready0), 32'd0);
    check("pin soft tick", 32'(tick0), 32'd0);
    repeat (27) @(negedge clk);
    check("pin soft E+27", 32'(rst0), 32'(4'b0111));
    @(negedge clk);
    check("pin soft E+28 rst", 32'(rst0), 32'(4'b1111));
    check("pin soft E+28 ready", 32'(ready0), 32'd1);

    // Late lock.
    rst_n = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    goto(29);  check("pin wait lock", 32'(rst0), 32'(4'b0000));
    pll_locked = 1'b1;
    goto(37);  check("pin late ch0 held", 32'(rst0), 32'(4'b0000));
    goto(38);  check("pin late ch0 rel", 32'(rst0), 32'(4'b0001));
    goto(61);  check("pin late ready low", 32'(ready0), 32'd0);
    goto(62);  check("pin late ready", 32'(ready0), 32'd1);

    // Lock lost mid-release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    goto(34);  check("pin pre-loss", 32'(rst0), 32'(4'b0011));
    pll_locked = 1'b0;
    goto(35);  check("pin loss rst", 32'(rst0), 32'(4'b0000));
               check("pin loss ready", 32'(ready0), 32'd0);
    goto(39);
    pll_locked = 1'b1;
    goto(47);  check("pin relock held", 32'(rst0), 32'(4'b0000));
    goto(48);  check("pin relock ch0", 32'(rst0), 32'(4'b0001));

    // One-cycle rst_n pulse in RUN.
    goto(80);  check("pin run before pulse", 32'(ready0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("pin pulse rst", 32'(rst0), 32'(4'b0000));
    check("pin pulse ready", 32'(ready0), 32'd0);
    check("pin pulse tick", 32'(tick0), 32'd0);
    rst_n = 1'b1;
    goto(23);  check("pin repor held", 32'(rst0), 32'(4'b0000));
    goto(24);  check("pin repor ch0", 32'(rst0), 32'(4'b0001));

    // Randomized traffic, checked by the model every cycle.
    repeat (4000) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if (pll_locked) pll_locked = ($urandom_range(0, 199) != 0);
      else            pll_locked = ($urandom_range(0, 7) == 0);
      if (soft_left > 0) soft_left--;
      else if ($urandom_range(0, 59) == 0) soft_left = $urandom_range(1, 40);
      soft_rst_req = (soft_left > 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
